ocpu_program_loader: RTL and testbench

Byte-stream boot loader that fills the OCPU (PicoBlaze) 1024x18 program RAM, directly upstream of the program memory's write port. Accepts a framed image from a byte source (UART/host bridge), packs 3 bytes per 18-bit instruction, and writes words sequentially from address 0. Holds the CPU in reset while loading and releases it only after a complete, valid image has been written.

---
 rtl/ocpu_program_loader.sv | 175 +++++++++++++++++
 tb/tb_ocpu_program_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ocpu_program_loader.sv
// Byte-stream boot loader for the OCPU 1024x18 program RAM: framed image in, one RAM write per 3 bytes.
// Define OCPU_PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module ocpu_program_loader #(
  parameter int         ADDRESS_WIDTH = 10,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     wr_enable,
  output logic [ADDRESS_WIDTH-1:0] wr_address,
  output logic [17:0]              wr_data,
  output logic                     cpu_reset,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, BYTE0, BYTE1, BYTE2, CHECK, RUN, FAIL
  } state_t;

  state_t                   state, state_n;
  logic [9:0]               len, len_n;
  logic [1:0]               b0, b0_n;
  logic [7:0]               b1, b1_n;
  logic [ADDRESS_WIDTH-1:0] idx, idx_n;
  logic                     wr_enable_n, cpu_reset_n, done_n, error_n;
  logic [ADDRESS_WIDTH-1:0] wr_address_n;
  logic [17:0]              wr_data_n;
  logic                     accept;
  logic                     last_word;
`ifdef OCPU_PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]               csum, csum_n;
`endif

  function automatic logic [17:0] pack_word(input logic [1:0] hi, input logic [7:0] mid,
                                            input logic [7:0] lo);
    return {hi, mid, lo};
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_word = (10'(idx) == len);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_enable  <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready   <= 1'b1;
      wr_enable  <= wr_enable_n;
      wr_address <= wr_address_n;
      wr_data    <= wr_data_n;
      cpu_reset  <= cpu_reset_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

  // Frame payload registers are reloaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    len <= len_n;
    b0  <= b0_n;
    b1  <= b1_n;
    idx <= idx_n;
`ifdef OCPU_PROGRAM_LOADER_CHECKSUM_EN
    csum <= csum_n;
`endif
  end

  always_comb begin
    state_n      = state;
    len_n        = len;
    b0_n         = b0;
    b1_n         = b1;
    idx_n        = idx;
    wr_enable_n  = 1'b0;
    wr_address_n = wr_address;
    wr_data_n    = wr_data;
    cpu_reset_n  = cpu_reset;
    done_n       = done;
    error_n      = error;
`ifdef OCPU_PROGRAM_LOADER_CHECKSUM_EN
    csum_n       = csum;
    if (accept && state inside {LEN_HI, LEN_LO, BYTE0, BYTE1, BYTE2})
      csum_n = csum ^ in_data;
`endif
    if (accept) begin
      case (state)
        IDLE, RUN, FAIL: begin
          // Only the sync byte is meaningful outside a frame.
          if (in_data == SYNC_BYTE) begin
            state_n      = LEN_HI;
            cpu_reset_n  = 1'b1;
            done_n       = 1'b0;
            error_n      = 1'b0;
            idx_n        = '0;
            wr_address_n = '0;
`ifdef OCPU_PROGRAM_LOADER_CHECKSUM_EN
            csum_n       = '0;
`endif
          end
        end
        LEN_HI: begin
          if (in_data[7:2] != 6'd0) begin
            state_n = FAIL;
            error_n = 1'b1;
          end else begin
            len_n[9:8] = in_data[1:0];
            state_n    = LEN_LO;
          end
        end
        LEN_LO: begin
          len_n[7:0] = in_data;
          state_n    = BYTE0;
        end
        BYTE0: begin
          if (in_data[7:2] != 6'd0) begin
            state_n = FAIL;
            error_n = 1'b1;
          end else begin
            b0_n    = in_data[1:0];
            state_n = BYTE1;
          end
        end
        BYTE1: begin
          b1_n    = in_data;
          state_n = BYTE2;
        end
        BYTE2: begin
          wr_enable_n  = 1'b1;
          wr_address_n = idx;
          wr_data_n    = pack_word(b0, b1, in_data);
          if (last_word) begin
`ifdef OCPU_PROGRAM_LOADER_CHECKSUM_EN
            state_n     = CHECK;
`else
            state_n     = RUN;
            cpu_reset_n = 1'b0;
            done_n      = 1'b1;
`endif
          end else begin
            idx_n   = idx + ADDRESS_WIDTH'(1);
            state_n = BYTE0;
          end
        end
        CHECK: begin
`ifdef OCPU_PROGRAM_LOADER_CHECKSUM_EN
          if (in_data == csum) begin
            state_n     = RUN;
            cpu_reset_n = 1'b0;
            done_n      = 1'b1;
          end else begin
            state_n = FAIL;
            error_n = 1'b1;
          end
`else
          state_n = FAIL;
          error_n = 1'b1;
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ocpu_program_loader.sv
// Scoreboard bench for ocpu_program_loader: expected RAM writes are queued as frames are sent.
module tb_ocpu_program_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          wr_enable;
  logic [AW-1:0] wr_address;
  logic [17:0]   wr_data;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int n_tests = 0;
  int n_fail = 0;
  int wr_count = 0;
  bit gaps = 1'b0;
  logic [17:0] img[$];
  logic [27:0] exp_q[$];

  ocpu_program_loader #(.ADDRESS_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && wr_enable === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(wr_address), 32'hFFFF_FFFF);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        check("wr_address", 32'(wr_address), 32'(e[27:18]));
        check("wr_data", 32'(wr_data), 32'(e[17:0]));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was consumed.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gaps) begin
      int g = $urandom_range(0, 2);
      repeat (g) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit good_chk);
    logic [9:0] len;
    logic [7:0] cs, x0, x1, x2;
    len = 10'(img.size() - 1);
    send_byte(8'hA5);
    send_byte({6'd0, len[9:8]});
    send_byte(len[7:0]);
    cs = {6'd0, len[9:8]} ^ len[7:0];
    foreach (img[i]) begin
      x0 = {6'd0, img[i][17:16]};
      x1 = img[i][15:8];
      x2 = img[i][7:0];
      cs = cs ^ x0 ^ x1 ^ x2;
      send_byte(x0);
      send_byte(x1);
      exp_q.push_back({10'(i), img[i]});
      send_byte(x2);
    end
`ifdef OCPU_PROGRAM_LOADER_CHECKSUM_EN
    send_byte(good_chk ? cs : (cs ^ 8'h01));
`else
    // Without a checksum stage a trailing non-sync byte must simply be dropped.
    if (!good_chk) send_byte((cs == 8'hA5) ? 8'h00 : cs);
`endif
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic cr);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_enable", 32'(wr_enable), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_wr_address", 32'(wr_address), 32'd0);
    check("idle_wr_data", 32'(wr_data), 32'd0);
    check_status("idle", 1'b0, 1'b0, 1'b1);

    // Garbage in IDLE
    send_byte(8'h00);
    send_byte(8'h13);
    repeat (2) @(negedge clk);
    check_status("garbage", 1'b0, 1'b0, 1'b1);
    check("garbage_writes", 32'(wr_count), 32'd0);

    // Single word
    img = '{18'h23456};
    send_frame(1'b1);
    check_status("one_word", 1'b1, 1'b0, 1'b0);
    check("one_word_writes", 32'(wr_count), 32'd1);
    check("one_word_queue", 32'(exp_q.size()), 32'd0);

    // Full 1024-word image with random idle gaps
    gaps = 1'b1;
    img.delete();
    for (int i = 0; i < 1024; i++) img.push_back(18'(i));
    send_frame(1'b1);
    gaps = 1'b0;
    repeat (5) @(negedge clk);
    check("full_writes", 32'(wr_count), 32'd1025);
    check("full_queue", 32'(exp_q.size()), 32'd0);
    check("full_last_addr", 32'(wr_address), 32'd1023);
    check_status("full", 1'b1, 1'b0, 1'b0);

    // Bad LEN_HI
    send_byte(8'hA5);
    send_byte(8'h04);
    check_status("len_err", 1'b0, 1'b1, 1'b1);

    // Bad B0 upper bits, then recovery
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h04);
    check_status("b0_err", 1'b0, 1'b1, 1'b1);
    send_byte(8'h05);
    send_byte(8'h06);
    repeat (2) @(negedge clk);
    check("b0_err_writes", 32'(wr_count), 32'd1025);
    img = '{18'h10203};
    send_frame(1'b1);
    check_status("recover", 1'b1, 1'b0, 1'b0);
    check("recover_queue", 32'(exp_q.size()), 32'd0);

    // Checksum byte: bad then good
    img = '{18'h1FFFF};
    send_frame(1'b0);
`ifdef OCPU_PROGRAM_LOADER_CHECKSUM_EN
    check_status("chk_bad", 1'b0, 1'b1, 1'b1);
`else
    check_status("chk_bad", 1'b1, 1'b0, 1'b0);
`endif
    check("chk_bad_writes", 32'(wr_count), 32'd1027);
    send_frame(1'b1);
    check_status("chk_good", 1'b1, 1'b0, 1'b0);

    // Reset after B1 of word 5
    base = wr_count;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h09);
    for (int w = 0; w < 5; w++) begin
      send_byte(8'h01);
      send_byte(8'(w));
      exp_q.push_back({10'(w), 2'b01, 8'(w), 8'h77});
      send_byte(8'h77);
    end
    send_byte(8'h02);
    send_byte(8'h33);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_wr_enable", 32'(wr_enable), 32'd0);
    check("midrst_wr_address", 32'(wr_address), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    check_status("midrst", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_writes", 32'(wr_count - base), 32'd5);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    img = '{18'h2ABCD};
    send_frame(1'b1);
    check_status("restart", 1'b1, 1'b0, 1'b0);
    check("restart_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
